// File: rtl/regfile_write_arbiter.sv
// Write-port owner for the 32x32 RegisterFile: round-robin sharing of
// we3/wa3/wd3 between NUM_REQ writeback sources, plus a zeroing sweep
// of r1..r(2**ADDR_W-1) after reset or on clear_start.
module regfile_write_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 5,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear_start,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         we3,
    output logic [ADDR_W-1:0]            wa3,
    output logic [DATA_W-1:0]            wd3,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id
);

    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic { S_ARB = 1'b0, S_CLEAR = 1'b1 } state_t;

    state_t              state;
    logic [GW-1:0]       ptr;
    logic [ADDR_W-1:0]   cnt;

    logic                found;
    logic [GW-1:0]       win;
    logic [GW:0]         idx;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_data;
    logic [GW-1:0]       ptr_nxt;

    // Round-robin search from ptr with wrap; nothing is granted while
    // clearing or on the cycle a clear is being requested.
    always_comb begin
        req_ready = '0;
        found     = 1'b0;
        win       = '0;
        idx       = '0;
        if (state == S_ARB && !clear_start) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                idx = {1'b0, ptr} + (GW+1)'(i);
                if (idx >= (GW+1)'(NUM_REQ))
                    idx = idx - (GW+1)'(NUM_REQ);
                if (!found && req_valid[idx[GW-1:0]]) begin
                    found = 1'b1;
                    win   = idx[GW-1:0];
                end
            end
            if (found)
                req_ready[win] = 1'b1;
        end
    end

    // Winner's payload and the pointer slot just past the winner.
    always_comb begin
        win_addr = req_addr[win*ADDR_W +: ADDR_W];
        win_data = req_data[win*DATA_W +: DATA_W];
        ptr_nxt  = (win == GW'(NUM_REQ-1)) ? '0 : win + GW'(1);
    end

    // State machine: sweep zeros through r1.. in CLEAR, forward the granted
    // request to the port one cycle later in ARB (writes to r0 dropped).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= CLEAR_ON_RESET ? S_CLEAR : S_ARB;
            busy     <= CLEAR_ON_RESET;
            we3      <= 1'b0;
            wa3      <= '0;
            wd3      <= '0;
            grant_id <= '0;
            ptr      <= '0;
            cnt      <= ADDR_W'(1);
        end else begin
            case (state)
                S_CLEAR: begin
                    we3 <= 1'b1;
                    wa3 <= cnt;
                    wd3 <= '0;
                    if (cnt == '1) begin
                        state <= S_ARB;
                        busy  <= 1'b0;
                        cnt   <= ADDR_W'(1);
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
                default: begin
                    if (clear_start) begin
                        we3   <= 1'b0;
                        state <= S_CLEAR;
                        busy  <= 1'b1;
                        cnt   <= ADDR_W'(1);
                    end else if (found) begin
                        we3      <= |win_addr;
                        wa3      <= win_addr;
                        wd3      <= win_data;
                        grant_id <= win;
                        ptr      <= ptr_nxt;
                    end else begin
                        we3 <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter (NUM_REQ=2) with a behavioural
// register file fed from the write port.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear_start;
    logic [1:0]  req_valid;
    logic [9:0]  req_addr;
    logic [63:0] req_data;
    logic [1:0]  req_ready;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic        busy;
    logic [0:0]  grant_id;

    regfile_write_arbiter #(
        .NUM_REQ(2), .DATA_W(32), .ADDR_W(5), .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear_start(clear_start),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .we3(we3), .wa3(wa3), .wd3(wd3),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    // Register file model: r0 starts at 0, others at recognisable garbage.
    logic [31:0] rf [32];
    logic        rf_init = 1'b0;
    always @(posedge clk) begin
        if (!rf_init) begin
            for (int i = 0; i < 32; i++)
                rf[i] <= (i == 0) ? 32'h0 : (32'hBAD0_0000 | i);
            rf_init <= 1'b1;
        end else if (we3) begin
            rf[wa3] <= wd3;
        end
    end

    int ntests = 0;
    int nfail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // 31-cycle zeroing sweep, entered just before the first clear edge.
    task automatic sweep(input string tag);
        for (int k = 1; k <= 31; k++) begin
            chk({tag, " ready"}, 32'(req_ready), 32'h0);
            step();
            chk({tag, " we3"}, 32'(we3), 32'h1);
            chk({tag, " wa3"}, 32'(wa3), 32'(k));
            chk({tag, " wd3"}, wd3, 32'h0);
            chk({tag, " busy"}, 32'(busy), (k < 31) ? 32'h1 : 32'h0);
        end
    endtask

    typedef struct {
        logic [1:0]  v;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic [1:0]  rdy;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        gid;
    } vec_t;

    vec_t tbl [15];

    initial begin
        // valid  a0  d0             a1  d1         rdy   we  wa  wd             gid
        tbl[0]  = '{2'b01, 18, 32'd255,       0,  32'd0,     2'b01, 1, 18, 32'd255,       0};
        tbl[1]  = '{2'b10, 0,  32'd0,         19, 32'd170,   2'b10, 1, 19, 32'd170,       1};
        tbl[2]  = '{2'b00, 0,  32'd0,         0,  32'd0,     2'b00, 0, 19, 32'd170,       1};
        tbl[3]  = '{2'b11, 5,  32'h55,        6,  32'h66,    2'b01, 1, 5,  32'h55,        0};
        tbl[4]  = '{2'b11, 5,  32'h55,        6,  32'h66,    2'b10, 1, 6,  32'h66,        1};
        tbl[5]  = '{2'b11, 5,  32'h55,        6,  32'h66,    2'b01, 1, 5,  32'h55,        0};
        tbl[6]  = '{2'b11, 5,  32'h55,        6,  32'h66,    2'b10, 1, 6,  32'h66,        1};
        tbl[7]  = '{2'b11, 5,  32'h55,        6,  32'h66,    2'b01, 1, 5,  32'h55,        0};
        tbl[8]  = '{2'b11, 5,  32'h55,        6,  32'h66,    2'b10, 1, 6,  32'h66,        1};
        tbl[9]  = '{2'b11, 5,  32'h55,        6,  32'h66,    2'b01, 1, 5,  32'h55,        0};
        tbl[10] = '{2'b11, 5,  32'h55,        6,  32'h66,    2'b10, 1, 6,  32'h66,        1};
        tbl[11] = '{2'b01, 0,  32'hDEADBEEF,  0,  32'd0,     2'b01, 0, 0,  32'hDEADBEEF,  0};
        tbl[12] = '{2'b11, 7,  32'h77,        8,  32'h88,    2'b10, 1, 8,  32'h88,        1};
        tbl[13] = '{2'b10, 0,  32'd0,         9,  32'h99,    2'b10, 1, 9,  32'h99,        1};
        tbl[14] = '{2'b00, 0,  32'd0,         0,  32'd0,     2'b00, 0, 9,  32'h99,        1};

        rst_n = 1'b0; clear_start = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;

        // Reset state, then the post-reset sweep.
        step(); step();
        chk("rst we3", 32'(we3), 32'h0);
        chk("rst wa3", 32'(wa3), 32'h0);
        chk("rst wd3", wd3, 32'h0);
        chk("rst gid", 32'(grant_id), 32'h0);
        chk("rst busy", 32'(busy), 32'h1);
        rst_n = 1'b1;
        sweep("clr0");
        step();
        for (int a = 0; a < 32; a++)
            chk($sformatf("clr0 rf[%0d]", a), rf[a], 32'h0);

        // Table-driven arbitration vectors.
        for (int i = 0; i < 15; i++) begin
            req_valid = tbl[i].v;
            req_addr  = {tbl[i].a1, tbl[i].a0};
            req_data  = {tbl[i].d1, tbl[i].d0};
            #1;
            chk($sformatf("v%0d ready", i), 32'(req_ready), 32'(tbl[i].rdy));
            step();
            chk($sformatf("v%0d we3", i), 32'(we3), 32'(tbl[i].we));
            chk($sformatf("v%0d wa3", i), 32'(wa3), 32'(tbl[i].wa));
            chk($sformatf("v%0d wd3", i), wd3, tbl[i].wd);
            chk($sformatf("v%0d gid", i), 32'(grant_id), 32'(tbl[i].gid));
        end
        step();
        chk("rf r0", rf[0], 32'h0);
        chk("rf r18", rf[18], 32'd255);
        chk("rf r19", rf[19], 32'd170);
        chk("rf r8", rf[8], 32'h88);

        // clear_start while req1 is pending: blocked, sweep, then served.
        clear_start = 1'b1;
        req_valid = 2'b10;
        req_addr  = {5'd20, 5'd0};
        req_data  = {32'h0000CAFE, 32'h0};
        #1;
        chk("clr1 ready", 32'(req_ready), 32'h0);
        step();
        clear_start = 1'b0;
        chk("clr1 we3", 32'(we3), 32'h0);
        chk("clr1 busy", 32'(busy), 32'h1);
        sweep("clr1");
        chk("post ready", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        chk("post we3", 32'(we3), 32'h1);
        chk("post wa3", 32'(wa3), 32'd20);
        chk("post wd3", wd3, 32'h0000CAFE);
        step();
        chk("rf r20", rf[20], 32'h0000CAFE);

        // Reset mid-clear at wa3=12, sweep must restart from r1.
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        for (int k = 0; k < 12; k++) step();
        chk("mid wa3", 32'(wa3), 32'd12);
        rst_n = 1'b0;
        step();
        chk("mid rst we3", 32'(we3), 32'h0);
        chk("mid rst wa3", 32'(wa3), 32'h0);
        chk("mid rst busy", 32'(busy), 32'h1);
        rst_n = 1'b1;
        sweep("clr2");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the single write port (we3/wa3/wd3) of the 32x32 RegisterFile and shares it between NUM_REQ writeback requesters using round-robin arbitration.
- Runs a clear sequence that writes 0 to r1..r31 after reset, and again on request, so register reads are deterministic.
- Sits between the writeback sources (ALU, load unit, ...) and RegisterFile. Its outputs drive we3, wa3 and wd3 directly.

Parameters:
- NUM_REQ, 2, number of write requesters (2..8).
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width; the register count is 2**ADDR_W.
- CLEAR_ON_RESET, 1, 1 = enter the CLEAR state on reset; 0 = enter the ARB state on reset.

Ports:
- clk, input, 1, single clock; all logic updates on the rising edge.
- rst_n, input, 1, synchronous active-low reset.
- clear_start, input, 1, one-cycle pulse that starts a clear sequence.
- req_valid, input, NUM_REQ, per-requester write request.
- req_addr, input, NUM_REQ*ADDR_W, packed destination addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_data, input, NUM_REQ*DATA_W, packed write data; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready, output, NUM_REQ, one-hot grant (combinational).
- we3, output, 1, registered write enable to RegisterFile.
- wa3, output, ADDR_W, registered write address.
- wd3, output, DATA_W, registered write data.
- busy, output, 1, registered; high while in the CLEAR state.
- grant_id, output, clog2(NUM_REQ), registered index of the last accepted requester.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - we3=0, wa3=0, wd3=0, grant_id=0.
  - Round-robin pointer = 0; clear counter = 1.
  - State = CLEAR with busy=1 if CLEAR_ON_RESET=1; otherwise state = ARB with busy=0.
  - Reset takes effect mid-clear or mid-arbitration; the sequence restarts from r1.
- CLEAR state:
  - req_ready is all zero.
  - Each cycle register we3=1, wa3=counter, wd3=0, then increment the counter.
  - When the counter reaches 2**ADDR_W-1, that write is the last one. Next state is ARB, busy falls, and the counter returns to 1.
  - A clear takes exactly 2**ADDR_W-1 cycles (31 by default). r0 is never written.
  - clear_start is ignored in CLEAR.
- ARB state, clear_start=1:
  - req_ready is all zero and no request is accepted that cycle.
  - Register we3=0. Next state is CLEAR, busy=1, counter=1.
- ARB state, clear_start=0:
  - Search req_valid starting at the pointer index, ascending with wrap-around. The first valid requester k gets req_ready[k]=1; all other ready bits are 0. At most one bit is set.
  - Transfer occurs when req_valid[k] and req_ready[k] are both high.
  - On transfer, next cycle: wa3=addr_k, wd3=data_k, grant_id=k, pointer=(k+1) mod NUM_REQ.
  - we3=1 unless addr_k==0. A write to r0 is still accepted (ready asserted, pointer advances) but is dropped with we3=0.
  - If no request is valid: we3=0, and wa3, wd3, grant_id and the pointer hold.
- Latency and throughput:
  - Accepted request to write on the port: 1 cycle.
  - One write per cycle sustained; with N contending requesters each is served once every N cycles.
- Handshake rules:
  - A requester holds valid, addr and data stable until accepted.
  - req_ready may depend combinationally on req_valid; a requester must not make valid depend on ready.
  - Dropping valid before acceptance is allowed and causes no write.
- Forwarding: none. Same-cycle read-after-write is not handled here; RegisterFile's write-then-read timing is unchanged.

Test Plan:
1. Reset with rst_n=0 for 2 cycles, then release -> busy=1 for 31 cycles; we3=1 with wa3 sweeping 1..31 and wd3=0; then busy=0 and RegisterFile rd1 reads 0 for every address.
2. After clear, req0 = (addr 18, data 255) for one cycle, then req1 = (addr 19, data 170) -> ready0 and ready1 each pulse once; next-cycle writes (18,255) then (19,170); reads r18=255, r19=170.
3. Both requesters held valid continuously with distinct addresses, pointer=0 -> grants alternate 0,1,0,1; grant_id matches; no grant missed or duplicated over 8 cycles.
4. req0 valid with addr=0, data=0xDEADBEEF -> ready0=1, we3=0 the next cycle, pointer advances to 1, r0 still reads 0.
5. clear_start pulses in ARB while req1 is valid -> ready1=0 that cycle; 31 clear writes follow; req1 is then accepted on the first ARB cycle; the final value of its register equals req1's data.
6. rst_n=0 while wa3=12 mid-clear -> next cycle we3=0; after release the sweep restarts at wa3=1 and completes in 31 cycles.
